// File: rtl/ram16_fifo_ctrl_if.sv
// Stream and RAM-pin bundle for ram16_fifo_ctrl.
// The master modport is the controller's view; slave is the environment (producer, consumer, RAM).
interface ram16_fifo_ctrl_if;
    logic       flush;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic [3:0] ram_ad;
    logic [7:0] ram_di;
    logic       ram_wre;
    logic [7:0] ram_dout;

    modport master (
        input  flush, s_data, s_valid, m_ready, ram_dout,
        output s_ready, m_data, m_valid, count, ram_ad, ram_di, ram_wre
    );

    modport slave (
        output flush, s_data, s_valid, m_ready, ram_dout,
        input  s_ready, m_data, m_valid, count, ram_ad, ram_di, ram_wre
    );
endinterface

// File: rtl/ram16_fifo_ctrl.sv
// 16-entry byte FIFO built on a single-port 16x8 RAM with a registered output stage.
// Entries 0..INIT_COUNT-1 of the RAM are treated as queued data after reset.
module ram16_fifo_ctrl #(
    parameter int INIT_COUNT = 0
) (
    input  logic              clk,
    input  logic              rst,
    ram16_fifo_ctrl_if.master bus
);

    localparam logic [4:0] INIT_CNT = INIT_COUNT[4:0];
    localparam logic [3:0] INIT_WP  = INIT_COUNT[3:0];

    logic [3:0] wr_ptr_r;
    logic [3:0] rd_ptr_r;
    logic [4:0] ram_cnt_r;
    logic       m_valid_r;
    logic [7:0] m_data_r;

    logic       rd_grant_s;
    logic       wr_grant_s;
    logic       s_ready_s;
    logic [3:0] ram_ad_s;

    // Port arbitration: refilling the output register beats accepting a new byte.
    always_comb begin
        rd_grant_s = 1'b0;
        s_ready_s  = 1'b0;
        wr_grant_s = 1'b0;
        ram_ad_s   = wr_ptr_r;
        if (!bus.flush && (ram_cnt_r != 5'd0) && (!m_valid_r || bus.m_ready)) begin
            rd_grant_s = 1'b1;
        end else begin
            rd_grant_s = 1'b0;
        end
        if (!bus.flush && !rd_grant_s && (ram_cnt_r < 5'd16)) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
        wr_grant_s = bus.s_valid && s_ready_s;
        if (rd_grant_s) begin
            ram_ad_s = rd_ptr_r;
        end else begin
            ram_ad_s = wr_ptr_r;
        end
    end

    // Pointer, occupancy and output-register state; flush clears everything but m_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= INIT_WP;
            rd_ptr_r  <= 4'd0;
            ram_cnt_r <= INIT_CNT;
            m_valid_r <= 1'b0;
            m_data_r  <= 8'd0;
        end else if (bus.flush) begin
            wr_ptr_r  <= 4'd0;
            rd_ptr_r  <= 4'd0;
            ram_cnt_r <= 5'd0;
            m_valid_r <= 1'b0;
        end else begin
            if (rd_grant_s) begin
                m_data_r  <= bus.ram_dout;
                m_valid_r <= 1'b1;
                rd_ptr_r  <= rd_ptr_r + 4'd1;
                ram_cnt_r <= ram_cnt_r - 5'd1;
            end else if (m_valid_r && bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
            if (wr_grant_s) begin
                wr_ptr_r  <= wr_ptr_r + 4'd1;
                ram_cnt_r <= ram_cnt_r + 5'd1;
            end
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_r;
    assign bus.count   = ram_cnt_r + {4'd0, m_valid_r};
    assign bus.ram_ad  = ram_ad_s;
    assign bus.ram_di  = bus.s_data;
    assign bus.ram_wre = wr_grant_s;

endmodule

// File: tb/tb_ram16_fifo_ctrl.sv
// Directed and randomized bench for ram16_fifo_ctrl (INIT_COUNT=4) against a queue-based model.
module tb_ram16_fifo_ctrl;

    localparam int INIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram16_fifo_ctrl_if bus ();

    ram16_fifo_ctrl #(.INIT_COUNT(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Behavioural RAM macro: synchronous write, combinational read.
    logic [7:0] mem [16] = '{8'h00, 8'h80, 8'h0F, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    always @(posedge clk) begin
        if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_di;
    end
    assign bus.ram_dout = mem[bus.ram_ad];

    int passed = 0;
    int total  = 0;

    // Reference model: queue of bytes held in RAM, output register, and access counts.
    logic [7:0] q [$];
    logic       mv;
    logic [7:0] md;
    int         nrd;
    int         nwr;
    logic       acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < INIT; i++) q.push_back(mem[i]);
        mv  = 1'b0;
        md  = 8'h00;
        nrd = 0;
        nwr = INIT;
    endtask

    task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
        logic rd, sr, wr;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        bus.flush   = fl;
        rd = !fl && (q.size() != 0) && (!mv || mr);
        sr = !fl && !rd && (q.size() < 16);
        wr = sv && sr;
        #2;
        chk("s_ready", bus.s_ready, sr);
        chk("ram_wre", bus.ram_wre, wr);
        chk("ram_ad", bus.ram_ad, rd ? (nrd % 16) : (nwr % 16));
        if (wr) chk("ram_di", bus.ram_di, sd);
        @(posedge clk);
        if (fl) begin
            q.delete();
            mv  = 1'b0;
            nrd = 0;
            nwr = 0;
        end else begin
            if (rd) begin
                md = q.pop_front();
                mv = 1'b1;
                nrd++;
            end else if (mv && mr) begin
                mv = 1'b0;
            end
            if (wr) begin
                q.push_back(sd);
                nwr++;
            end
        end
        acc = wr;
        #1;
        chk("m_valid", bus.m_valid, mv);
        chk("m_data", bus.m_data, md);
        chk("count", bus.count, q.size() + int'(mv));
    endtask

    initial begin
        logic [7:0] d;
        int guard;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        bus.flush   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 5'd4);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        rst = 1'b0;

        // Preload stream drains in order 00,80,0F,F0.
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("boot_empty_count", bus.count, 5'd0);
        chk("boot_last_data", bus.m_data, 8'hF0);

        // Single byte into an empty FIFO, consumer stalled.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("a5_out", bus.m_data, 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to 17 with 0x10.., then drain through the pointer wrap.
        d = 8'h10;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, d, 1'b0, 1'b0);
            if (acc) d = d + 8'd1;
        end
        chk("full_count", bus.count, 5'd17);
        chk("full_s_ready", bus.s_ready, 1'b0);
        chk("full_head", bus.m_data, 8'h10);
        repeat (40) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Continuous streaming: writes and refills alternate.
        for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));

        // Build count=9 then flush with live handshakes.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        guard = 0;
        while (bus.count != 5'd9 && guard < 60) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            guard++;
        end
        chk("reach9", bus.count, 5'd9);
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        chk("post_flush_ad", bus.ram_ad, 4'd0);
        repeat (4) step(1'b1, 8'($urandom), 1'b1, 1'b0);

        // Async reset while a write is in progress with five bytes in RAM.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        guard = 0;
        while (q.size() != 5 && guard < 60) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            guard++;
        end
        chk("reach5", q.size(), 5);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        #2;
        rst = 1'b1;
        #1;
        chk("async_m_valid", bus.m_valid, 1'b0);
        chk("async_count", bus.count, 5'd4);
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
